// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with per-lane write enables and a registered read.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [BYTE_LANES-1:0] be_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read register only updates on reads, so it holds the last read word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned i = 0; i < BYTE_LANES; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: one request at a time, fixed wait states, single-cycle response.
// Optional byte-lane write strobes (req_be) enabled by defining MEM_BYTE_STROBE_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
`ifdef MEM_BYTE_STROBE_EN
    input  logic [BYTE_LANES-1:0] req_be,
`endif
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
    logic                    we_q, we_d;
    logic [WIDX_W-1:0]       widx_q, widx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [BYTE_LANES-1:0]   be_q, be_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_rd_q, rsp_rd_d;
    logic                    in_range;
    logic                    mem_en;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];
    assign in_range        = (widx_q < DEPTH_IDX);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        we_d        = we_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rd_d    = rsp_rd_q;
        req_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    we_d    = req_we;
                    widx_d  = req_addr[ADDR_W-1:2];
                    wdata_d = req_wdata;
`ifdef MEM_BYTE_STROBE_EN
                    be_d    = req_be;
`else
                    be_d    = '1;
`endif
                    wcnt_d  = WAIT_LD;
                    state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q <= 1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = !in_range;
                rsp_rd_d    = in_range && !we_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        widx_q  <= widx_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // RAM op happens on the edge leaving ACCESS; a reset on that edge cancels it.
    assign mem_en = (state_q == ACCESS) && in_range && !rst;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .en_i    (mem_en),
        .we_i    (we_q),
        .be_i    (be_q),
        .addr_i  (widx_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Read data is only exposed when the latest response was an in-range read.
    assign rsp_rdata = rsp_rd_q ? ram_rdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with different wait-state counts checked against a transaction-level memory model.
module tb_mem_responder;

    localparam int DEP = 64;
    localparam int NI  = 3;
    localparam int WT [NI] = '{1, 0, 3};
`ifdef MEM_BYTE_STROBE_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        valid [NI];
    logic        ready [NI];
    logic        rv    [NI];
    logic        rerr  [NI];
    logic [31:0] rdata [NI];

    logic [31:0] mdl     [NI][DEP];
    txn_t        pt      [NI];
    bit          pv      [NI];
    logic [31:0] last_rd [NI];
    logic        last_err[NI];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder #(
            .DEPTH       (DEP),
            .WAIT_CYCLES (WT[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (valid[g]),
            .req_ready (ready[g]),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
`ifdef MEM_BYTE_STROBE_EN
            .req_be    (req_be),
`endif
            .rsp_valid (rv[g]),
            .rsp_rdata (rdata[g]),
            .rsp_err   (rerr[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock for instance sel: record an accept, then check outputs against the model.
    task automatic tick(input int sel);
        bit          acc;
        bit          exp_v;
        logic [31:0] idx;
        txn_t        t;
        acc = (valid[sel] === 1'b1) && (ready[sel] === 1'b1);
        if (acc) begin
            check($sformatf("single_outstanding[%0d]", sel), {31'b0, pv[sel]}, 32'd0);
            t.due   = cyc + 1 + 1 + WT[sel];
            t.we    = req_we;
            t.addr  = req_addr;
            t.wdata = req_wdata;
            t.be    = BE_EN ? req_be : 4'hF;
            pt[sel] = t;
            pv[sel] = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        exp_v = pv[sel] && (pt[sel].due == cyc);
        check($sformatf("rsp_valid[%0d]", sel), {31'b0, rv[sel]}, {31'b0, exp_v});
        if (exp_v) begin
            pv[sel] = 1'b0;
            t       = pt[sel];
            idx     = t.addr >> 2;
            if (idx >= DEP) begin
                last_rd[sel]  = '0;
                last_err[sel] = 1'b1;
            end else if (t.we) begin
                for (int i = 0; i < 4; i++)
                    if (t.be[i]) mdl[sel][idx][8*i +: 8] = t.wdata[8*i +: 8];
                last_rd[sel]  = '0;
                last_err[sel] = 1'b0;
            end else begin
                last_rd[sel]  = mdl[sel][idx];
                last_err[sel] = 1'b0;
            end
        end
        check($sformatf("rsp_rdata[%0d]", sel), rdata[sel], last_rd[sel]);
        check($sformatf("rsp_err[%0d]", sel), {31'b0, rerr[sel]}, {31'b0, last_err[sel]});
        check($sformatf("req_ready[%0d]", sel), {31'b0, ready[sel]}, {31'b0, (!pv[sel] && !rst)});
    endtask

    task automatic send(input int sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input bit scr);
        int n;
        n = 0;
        while (ready[sel] !== 1'b1 && n < 40) begin
            tick(sel);
            n++;
        end
        if (n >= 40) check($sformatf("ready_timeout[%0d]", sel), {31'b0, ready[sel]}, 32'd1);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_be     = be;
        valid[sel] = 1'b1;
        tick(sel);
        valid[sel] = 1'b0;
        n = 0;
        while (pv[sel] && n < 40) begin
            if (scr) begin
                req_we    = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_be    = 4'($urandom);
            end
            tick(sel);
            n++;
        end
        if (pv[sel]) begin
            check($sformatf("rsp_timeout[%0d]", sel), {31'b0, pv[sel]}, 32'd0);
            pv[sel] = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned idx;
        idx = ($urandom_range(7) == 0) ? $urandom_range(DEP, 4 * DEP) : $urandom_range(DEP - 1);
        return 32'(idx * 4 + $urandom_range(3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int          n;

        rst = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        for (int s = 0; s < NI; s++) begin
            valid[s] = 1'b0; pv[s] = 1'b0; last_rd[s] = '0; last_err[s] = 1'b0;
            for (int i = 0; i < DEP; i++) mdl[s][i] = 'x;
        end

        tick(0);
        tick(0);
        rst = 1'b0;
        for (int s = 0; s < NI; s++) tick(s);

        for (int s = 0; s < NI; s++)
            for (int i = 0; i < DEP; i++)
                send(s, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);

        send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        check("wr10_err", {31'b0, rerr[0]}, 32'd0);
        send(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        check("rd10_data", rdata[0], 32'hDEADBEEF);
        send(0, 1'b0, 32'h13, 32'h0, 4'hF, 1'b1);
        check("rd13_data", rdata[0], 32'hDEADBEEF);

        saved = mdl[0][DEP-1];
        send(0, 1'b0, 32'(4 * DEP), 32'h0, 4'hF, 1'b0);
        check("oor_rd_err", {31'b0, rerr[0]}, 32'd1);
        check("oor_rd_data", rdata[0], 32'h0);
        send(0, 1'b1, 32'(4 * DEP), ~saved, 4'hF, 1'b0);
        check("oor_wr_err", {31'b0, rerr[0]}, 32'd1);
        check("oor_wr_data", rdata[0], 32'h0);
        send(0, 1'b0, 32'(4 * (DEP - 1)), 32'h0, 4'hF, 1'b0);
        check("last_word_kept", rdata[0], saved);
        send(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);

`ifdef MEM_BYTE_STROBE_EN
        send(0, 1'b1, 32'h40, 32'h11223344, 4'hF, 1'b0);
        send(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0);
        send(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
        check("be_merge", rdata[0], 32'h11BB33DD);
        send(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b0);
        check("be_zero_err", {31'b0, rerr[0]}, 32'd0);
        send(0, 1'b0, 32'h40, 32'h0, 4'hA, 1'b0);
        check("be_zero_kept", rdata[0], 32'h11BB33DD);
`endif

        send(2, 1'b1, 32'h44, 32'h5A5A1234, 4'hF, 1'b1);
        send(2, 1'b0, 32'h44, 32'h0, 4'hF, 1'b1);
        check("toggle_midwait", rdata[2], 32'h5A5A1234);

        valid[1] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            req_we    = 1'($urandom);
            req_addr  = rand_addr();
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            tick(1);
        end
        valid[1] = 1'b0;
        n = 0;
        while (pv[1] && n < 10) begin
            tick(1);
            n++;
        end

        saved     = mdl[2][8];
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = ~saved;
        req_be    = 4'hF;
        valid[2]  = 1'b1;
        tick(2);
        valid[2]  = 1'b0;
        tick(2);
        rst = 1'b1;
        for (int s = 0; s < NI; s++) begin
            pv[s] = 1'b0; last_rd[s] = '0; last_err[s] = 1'b0;
        end
        tick(2);
        rst = 1'b0;
        repeat (6) tick(2);
        send(2, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        check("rst_drop_kept", rdata[2], saved);

        for (int s = 0; s < NI; s++)
            for (int k = 0; k < 30; k++)
                send(s, 1'($urandom), rand_addr(), $urandom,
                     BE_EN ? 4'($urandom) : 4'hF, 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
